// File: rtl/key_event_filter.sv
// Keyboard front end for the game-state controller: debounces the raw two-slot
// keycode word and turns key transitions into single-cycle press/navigation pulses.
module key_event_filter #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY  = 30,
  parameter int unsigned REPEAT_RATE   = 6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] keycode_raw,
  input  logic        frame_tick,
  output logic [15:0] keycode_stable,
  output logic        any_key,
  output logic        enter_press,
  output logic        esc_press,
  output logic        pause_press,
  output logic        nav_up,
  output logic        nav_down
);

  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_ESC   = 8'h29;
  localparam logic [7:0] KEY_P     = 8'h13;
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_S     = 8'h16;

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  localparam int unsigned FC_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned FC_W   = $clog2(FC_MAX + 1);
  localparam logic [FC_W-1:0] DELAY_LAST = FC_W'(REPEAT_DELAY - 1);
  localparam logic [FC_W-1:0] RATE_LAST  = FC_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN
  } dir_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT
  } state_t;

  function automatic logic key_in(input logic [15:0] word, input logic [7:0] key);
    return (word[15:8] == key) || (word[7:0] == key);
  endfunction

  // ---------------------------------------------------------------- debounce
  logic [15:0]      raw_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             accept;

  // cnt holds (run length of raw_q) - 1, so the reset value counts raw_q = 0 once.
  always_comb begin
    cnt_next = '0;
    if (keycode_raw == raw_q) begin
      cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    end
    accept = (cnt_next == CNT_MAX);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      raw_q          <= '0;
      cnt            <= '0;
      keycode_stable <= '0;
    end else begin
      raw_q <= keycode_raw;
      cnt   <= cnt_next;
      if (accept) begin
        keycode_stable <= keycode_raw;
      end
    end
  end

  assign any_key = (keycode_stable != '0);

  // ------------------------------------------------------------ press pulses
  logic [15:0] stable_prev;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stable_prev <= '0;
      enter_press <= 1'b0;
      esc_press   <= 1'b0;
      pause_press <= 1'b0;
    end else begin
      stable_prev <= keycode_stable;
      enter_press <= key_in(keycode_stable, KEY_ENTER) && !key_in(stable_prev, KEY_ENTER);
      esc_press   <= key_in(keycode_stable, KEY_ESC)   && !key_in(stable_prev, KEY_ESC);
      pause_press <= key_in(keycode_stable, KEY_P)     && !key_in(stable_prev, KEY_P);
    end
  end

  // -------------------------------------------------------- nav auto-repeat
  logic up_req;
  logic down_req;
  dir_t cur_dir;

  always_comb begin
    up_req   = key_in(keycode_stable, KEY_UP)   || key_in(keycode_stable, KEY_W);
    down_req = key_in(keycode_stable, KEY_DOWN) || key_in(keycode_stable, KEY_S);
    cur_dir  = DIR_NONE;
    if (up_req && !down_req) begin
      cur_dir = DIR_UP;
    end else if (down_req && !up_req) begin
      cur_dir = DIR_DOWN;
    end
  end

  state_t          state;
  state_t          state_n;
  dir_t            dir;
  dir_t            dir_n;
  logic [FC_W-1:0] fcnt;
  logic [FC_W-1:0] fcnt_n;
  logic [FC_W-1:0] fcnt_last;
  logic            fire;
  logic            nav_up_n;
  logic            nav_down_n;

  always_comb begin
    state_n   = state;
    dir_n     = dir;
    fcnt_n    = fcnt;
    fire      = 1'b0;
    fcnt_last = (state == S_DELAY) ? DELAY_LAST : RATE_LAST;

    case (state)
      S_IDLE: begin
        if (cur_dir != DIR_NONE) begin
          fire    = 1'b1;
          dir_n   = cur_dir;
          fcnt_n  = '0;
          state_n = S_DELAY;
        end
      end
      S_DELAY, S_REPEAT: begin
        if (cur_dir == DIR_NONE) begin
          fcnt_n  = '0;
          state_n = S_IDLE;
        end else if (cur_dir != dir) begin
          // Reversal fires immediately; any frame_tick this cycle is dropped.
          fire    = 1'b1;
          dir_n   = cur_dir;
          fcnt_n  = '0;
          state_n = S_DELAY;
        end else if (frame_tick) begin
          if (fcnt == fcnt_last) begin
            fire    = 1'b1;
            fcnt_n  = '0;
            state_n = S_REPEAT;
          end else begin
            fcnt_n = fcnt + 1'b1;
          end
        end
      end
      default: begin
        fcnt_n  = '0;
        state_n = S_IDLE;
      end
    endcase

    // dir_n always names the direction being pulsed whenever fire is set.
    nav_up_n   = fire && (dir_n == DIR_UP);
    nav_down_n = fire && (dir_n == DIR_DOWN);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      dir      <= DIR_NONE;
      fcnt     <= '0;
      nav_up   <= 1'b0;
      nav_down <= 1'b0;
    end else begin
      state    <= state_n;
      dir      <= dir_n;
      fcnt     <= fcnt_n;
      nav_up   <= nav_up_n;
      nav_down <= nav_down_n;
    end
  end

endmodule

// File: tb/tb_key_event_filter.sv
// Self-checking bench for key_event_filter: fixed vector table, directed
// navigation/reset sequences, and random stimulus against a reference model.
module tb_key_event_filter;

  localparam int SC = 4;
  localparam int RD = 30;
  localparam int RR = 6;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] keycode_raw;
  logic        frame_tick;
  logic [15:0] keycode_stable;
  logic        any_key;
  logic        enter_press;
  logic        esc_press;
  logic        pause_press;
  logic        nav_up;
  logic        nav_down;

  key_event_filter #(
    .STABLE_CYCLES(SC),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .keycode_raw   (keycode_raw),
    .frame_tick    (frame_tick),
    .keycode_stable(keycode_stable),
    .any_key       (any_key),
    .enter_press   (enter_press),
    .esc_press     (esc_press),
    .pause_press   (pause_press),
    .nav_up        (nav_up),
    .nav_down      (nav_down)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  int up_cnt;
  int down_cnt;

  // ------------------------------------------------------- reference model
  logic [15:0] hist[$];
  logic [15:0] m_stable, m_prev;
  logic        m_enter, m_esc, m_pause, m_up, m_down;
  int          m_active;  // 0 none, 1 up, 2 down
  int          m_ticks;   // frame ticks seen since the current direction began

  function automatic logic has(input logic [15:0] w, input logic [7:0] k);
    return (w[15:8] == k) || (w[7:0] == k);
  endfunction

  function automatic int dir_of(input logic [15:0] w);
    logic u, d;
    u = has(w, 8'h52) || has(w, 8'h1A);
    d = has(w, 8'h51) || has(w, 8'h16);
    if (u && !d) return 1;
    if (d && !u) return 2;
    return 0;
  endfunction

  task automatic model_edge(input logic rst, input logic [15:0] raw, input logic tick);
    int  d;
    logic pulse;
    logic same;
    if (rst) begin
      hist.delete();
      hist.push_back(16'h0000);
      m_stable = '0; m_prev = '0;
      m_enter = 0; m_esc = 0; m_pause = 0; m_up = 0; m_down = 0;
      m_active = 0; m_ticks = 0;
      return;
    end
    m_enter = has(m_stable, 8'h28) && !has(m_prev, 8'h28);
    m_esc   = has(m_stable, 8'h29) && !has(m_prev, 8'h29);
    m_pause = has(m_stable, 8'h13) && !has(m_prev, 8'h13);
    pulse = 0;
    d = dir_of(m_stable);
    if (d == 0) begin
      m_active = 0;
    end else if (d != m_active) begin
      m_active = d; m_ticks = 0; pulse = 1;
    end else if (tick) begin
      m_ticks++;
      if (m_ticks == RD || (m_ticks > RD && (m_ticks - RD) % RR == 0)) pulse = 1;
    end
    m_up   = pulse && (d == 1);
    m_down = pulse && (d == 2);
    m_prev = m_stable;
    hist.push_back(raw);
    while (hist.size() > SC) void'(hist.pop_front());
    if (hist.size() == SC) begin
      same = 1;
      foreach (hist[i]) if (hist[i] != raw) same = 0;
      if (same) m_stable = raw;
    end
  endtask

  // ------------------------------------------------------------ checking
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("stable",  32'(keycode_stable), 32'(m_stable));
    chk("any_key", 32'(any_key),        32'(m_stable != 16'h0));
    chk("enter",   32'(enter_press),    32'(m_enter));
    chk("esc",     32'(esc_press),      32'(m_esc));
    chk("pause",   32'(pause_press),    32'(m_pause));
    chk("nav_up",  32'(nav_up),         32'(m_up));
    chk("nav_down",32'(nav_down),       32'(m_down));
  endtask

  task automatic step(input logic rst, input logic [15:0] raw, input logic tick);
    Reset = rst; keycode_raw = raw; frame_tick = tick;
    @(posedge Clk);
    model_edge(rst, raw, tick);
    #1;
    check_model();
    if (nav_up)   up_cnt++;
    if (nav_down) down_cnt++;
  endtask

  // -------------------------------------------------------------- vectors
  typedef struct {
    logic        rst;
    logic [15:0] raw;
    logic [15:0] exp_stable;
    logic        exp_enter;
    logic        exp_pause;
  } vec_t;

  vec_t vecs[$];

  logic [15:0] pool[12] = '{16'h0000, 16'h0028, 16'h0029, 16'h0013, 16'h0052, 16'h1A00,
                            16'h0051, 16'h1600, 16'h5251, 16'h2813, 16'h2852, 16'h5200};

  initial begin
    Reset = 1; keycode_raw = '0; frame_tick = 0;
    up_cnt = 0; down_cnt = 0;

    // Enter press, glitch rejection, slot move plus new P, reset, short glitch.
    vecs.push_back('{1, 16'h0000, 16'h0000, 0, 0});
    vecs.push_back('{0, 16'h0028, 16'h0000, 0, 0});
    vecs.push_back('{0, 16'h0028, 16'h0000, 0, 0});
    vecs.push_back('{0, 16'h0028, 16'h0000, 0, 0});
    vecs.push_back('{0, 16'h0028, 16'h0028, 0, 0});
    vecs.push_back('{0, 16'h0028, 16'h0028, 1, 0});
    vecs.push_back('{0, 16'h0028, 16'h0028, 0, 0});
    vecs.push_back('{0, 16'h2813, 16'h0028, 0, 0});
    vecs.push_back('{0, 16'h2813, 16'h0028, 0, 0});
    vecs.push_back('{0, 16'h0028, 16'h0028, 0, 0});
    vecs.push_back('{0, 16'h2813, 16'h0028, 0, 0});
    vecs.push_back('{0, 16'h2813, 16'h0028, 0, 0});
    vecs.push_back('{0, 16'h2813, 16'h0028, 0, 0});
    vecs.push_back('{0, 16'h2813, 16'h2813, 0, 0});
    vecs.push_back('{0, 16'h2813, 16'h2813, 0, 1});
    vecs.push_back('{0, 16'h2813, 16'h2813, 0, 0});
    vecs.push_back('{1, 16'h2813, 16'h0000, 0, 0});
    vecs.push_back('{0, 16'h0028, 16'h0000, 0, 0});
    vecs.push_back('{0, 16'h0028, 16'h0000, 0, 0});
    for (int i = 0; i < 5; i++) vecs.push_back('{0, 16'h0000, 16'h0000, 0, 0});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].raw, 1'b0);
      chk($sformatf("tbl%0d_stable", i), 32'(keycode_stable), 32'(vecs[i].exp_stable));
      chk($sformatf("tbl%0d_enter", i),  32'(enter_press),    32'(vecs[i].exp_enter));
      chk($sformatf("tbl%0d_pause", i),  32'(pause_press),    32'(vecs[i].exp_pause));
    end

    // Held Up arrow with a frame tick every 10 clocks: press + tick 30 + every 6 to 396.
    step(1, 16'h0000, 0);
    up_cnt = 0; down_cnt = 0;
    for (int i = 0; i < 9; i++) step(0, 16'h0052, 0);
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < 9; i++) step(0, 16'h0052, 0);
      step(0, 16'h0052, 1);
    end
    for (int i = 0; i < 3; i++) step(0, 16'h0052, 0);
    chk("hold_up_count", 32'(up_cnt), 32'd63);
    chk("hold_up_down",  32'(down_cnt), 32'd0);

    // Both directions cancel; releasing Up leaves a single Down press.
    up_cnt = 0; down_cnt = 0;
    for (int i = 0; i < 8; i++) step(0, 16'h5251, 0);
    chk("both_up",   32'(up_cnt),   32'd0);
    chk("both_down", 32'(down_cnt), 32'd0);
    for (int i = 0; i < 8; i++) step(0, 16'h0051, 0);
    chk("release_down", 32'(down_cnt), 32'd1);
    chk("release_up",   32'(up_cnt),   32'd0);

    // Reset during REPEAT with W held; repeat timing restarts after re-debounce.
    step(1, 16'h001A, 0);
    for (int i = 0; i < 90; i++) step(0, 16'h001A, 1'(i % 2));
    for (int i = 0; i < 2; i++) begin
      step(1, 16'h001A, 1);
      chk("rst_outputs",
          32'({keycode_stable, any_key, enter_press, esc_press, pause_press, nav_up, nav_down}),
          32'd0);
    end
    up_cnt = 0;
    for (int i = 0; i < 100; i++) step(0, 16'h001A, 1'(i % 2));
    chk("rst_repeat_count", 32'(up_cnt), 32'd5);

    // Random stimulus against the model.
    for (int seg = 0; seg < 150; seg++) begin
      logic [15:0] k;
      int len;
      k   = ($urandom_range(0, 9) == 0) ? 16'($urandom) : pool[$urandom_range(0, 11)];
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 120);
      for (int i = 0; i < len; i++)
        step(1'($urandom_range(0, 499) == 0), k, 1'($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_event_filter.md
Name: key_event_filter

Overview:
- Sits directly upstream of the game-state controller.
- Takes the raw two-slot USB keycode word written by the NIOS keyboard driver, debounces it, and produces a stable keycode word plus single-cycle key-press event pulses (Enter, Escape, Pause).
- Also produces menu-navigation pulses with auto-repeat timed in video frames.
- The controller consumes keycode_stable and the pulses instead of the raw keycode, so one physical press advances state exactly once.

Parameters:
- STABLE_CYCLES, 4: consecutive Clk edges keycode_raw must hold a value before it is accepted (≥1).
- REPEAT_DELAY, 30: frame_tick count from a nav press to the first auto-repeat (≥1).
- REPEAT_RATE, 6: frame_tick count between subsequent auto-repeats (≥1).

Ports:
- Clk, input, 1: system clock.
- Reset, input, 1: synchronous, active-high reset.
- keycode_raw, input, 16: two USB HID keycodes, [15:8] and [7:0]; 8'h00 = empty slot.
- frame_tick, input, 1: one-Clk pulse per video frame (vsync-derived).
- keycode_stable, output, 16: debounced keycode word.
- any_key, output, 1: keycode_stable != 0.
- enter_press, output, 1: one-cycle pulse on new Enter (8'h28).
- esc_press, output, 1: one-cycle pulse on new Escape (8'h29).
- pause_press, output, 1: one-cycle pulse on new P (8'h13).
- nav_up, output, 1: one-cycle navigation pulse, Up arrow (8'h52) or W (8'h1A).
- nav_down, output, 1: one-cycle navigation pulse, Down arrow (8'h51) or S (8'h16).

Behaviour:
- Reset (synchronous, highest priority): keycode_stable = 0, any_key = 0, all pulses = 0. Sample register and debounce counter cleared. Repeat FSM = IDLE, frame counter = 0.
- Debounce:
  - raw_q samples keycode_raw every edge. When keycode_raw != raw_q, the counter clears to 0.
  - When keycode_raw has been sampled equal to value V on STABLE_CYCLES consecutive edges, keycode_stable <= V on the last of those edges.
  - Glitches shorter than STABLE_CYCLES edges never reach keycode_stable. STABLE_CYCLES = 1 gives a single-register delay.
  - Counter saturates and does not wrap.
- Key presence: in(K) = (keycode_stable[15:8] == K) or (keycode_stable[7:0] == K). K = 8'h00 is never a key.
- Press pulses:
  - stable_prev holds the previous keycode_stable.
  - A pulse is asserted, registered, one cycle after keycode_stable changes, when in(K) is 1 now and was 0 in stable_prev.
  - A key moving between slots is not a new press.
  - Different keys pressed in the same update each pulse in the same cycle.
- Nav direction: up_req = in(52) or in(1A); down_req = in(51) or in(16). Both or neither asserted = no direction.
- Repeat FSM (states IDLE, DELAY, REPEAT; registers dir, fcnt):
  - IDLE: on a new direction → pulse that direction's output, dir <= it, fcnt <= 0, go to DELAY.
  - DELAY: fcnt increments on frame_tick. When fcnt reaches REPEAT_DELAY-1 on a frame_tick → pulse dir, fcnt <= 0, go to REPEAT.
  - REPEAT: same counting, using REPEAT_RATE-1. Pulse dir and stay in REPEAT.
  - In DELAY or REPEAT, no direction → IDLE with no pulse, same cycle as the direction drops.
  - In DELAY or REPEAT, opposite direction → immediate pulse of the new direction, restart DELAY.
  - Nav pulse timing matches the press pulses: one cycle after keycode_stable changes.
  - nav_up and nav_down are never high together.
- frame_tick is ignored in IDLE. A frame_tick in the same cycle as a direction change is ignored, because the counter restarts.
- Reset mid-repeat → IDLE with no pulse. A key still held after reset produces a fresh press pulse once it is re-debounced.

Test Plan:
- Reset, keycode_raw = 16'h0028 held 10 cycles → keycode_stable = 16'h0028 after 4 edges; enter_press high exactly 1 cycle, one cycle later; any_key = 1.
- keycode_raw = 16'h0028 for 2 cycles, then 16'h0000 → keycode_stable stays 0, no enter_press.
- Hold 16'h0052 with frame_tick every 10 clocks, 400 ticks → nav_up at press; then 30 ticks later; then every 6 ticks. nav_down never asserts.
- Hold 16'h5251 (both directions) → no nav pulses. Release 16'h0051 → one nav_down pulse, one cycle after stable update.
- 16'h0028 → 16'h2813 → pause_press only. Enter does not re-pulse; keycode_stable = 16'h2813.
- Reset asserted during REPEAT with 16'h001A held → all outputs 0 during reset. After release, nav_up pulses once after re-debounce; repeat timing restarts from REPEAT_DELAY.
